// File: rtl/sample_rate_controller.sv
// sample_rate_controller: paces audio sample requests with a runtime-adjustable period divider
// Parameters:
//   DEFAULT_DIV - divider loaded at reset and on speed_reset
//   MIN_DIV     - lowest legal divider (fastest rate)
//   MAX_DIV     - highest legal divider (slowest rate)
//   STEP        - divider change per speed request
// Ports:
//   input_clock  - system clock, all logic on its rising edge
//   reset        - synchronous, active-low reset
//   speed_up     - pulse: shorten the pending divider by STEP (clamped at MIN_DIV)
//   speed_down   - pulse: lengthen the pending divider by STEP (clamped at MAX_DIV)
//   speed_reset  - pulse: restore DEFAULT_DIV as the pending divider
//   pause        - level: high freezes period counting
//   sample_ack   - consumer acknowledge of sample_req
//   sample_req   - request for the next sample, held until acknowledged
//   divider_out  - active divider
//   overrun      - sticky: a period elapsed while a request was still pending
//   running      - high while the run FSM is in RUN
module sample_rate_controller #(
    parameter logic [31:0] DEFAULT_DIV = 32'd1136,
    parameter logic [31:0] MIN_DIV     = 32'd568,
    parameter logic [31:0] MAX_DIV     = 32'd4544,
    parameter logic [31:0] STEP        = 32'd64
) (
    input  logic        input_clock,
    input  logic        reset,
    input  logic        speed_up,
    input  logic        speed_down,
    input  logic        speed_reset,
    input  logic        pause,
    input  logic        sample_ack,
    output logic        sample_req,
    output logic [31:0] divider_out,
    output logic        overrun,
    output logic        running
);
    typedef enum logic {PAUSED, RUN} run_state_t;
    typedef enum logic {REQ_IDLE, REQ_PEND} hs_state_t;

    run_state_t  run_q, run_d;
    hs_state_t   hs_q, hs_d;
    logic [31:0] pending_div_q, pending_div_d;
    logic [31:0] active_div_q, active_div_d;
    logic [31:0] cnt_q, cnt_d;
    logic        overrun_q, overrun_d;
    logic        boundary;
    logic [32:0] inc_wide;
    logic [31:0] dec_div, inc_div;

    always_ff @(posedge input_clock) begin
        if (!reset) begin
            run_q         <= RUN;
            hs_q          <= REQ_IDLE;
            pending_div_q <= DEFAULT_DIV;
            active_div_q  <= DEFAULT_DIV;
            cnt_q         <= 32'd0;
            overrun_q     <= 1'b0;
        end else begin
            run_q         <= run_d;
            hs_q          <= hs_d;
            pending_div_q <= pending_div_d;
            active_div_q  <= active_div_d;
            cnt_q         <= cnt_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        // 33-bit clamp arithmetic keeps the subtraction from underflowing and the addition from wrapping
        dec_div  = ({1'b0, pending_div_q} < ({1'b0, STEP} + {1'b0, MIN_DIV})) ? MIN_DIV : pending_div_q - STEP;
        inc_wide = {1'b0, pending_div_q} + {1'b0, STEP};
        inc_div  = (inc_wide > {1'b0, MAX_DIV}) ? MAX_DIV : inc_wide[31:0];
        // >= lets a divider that shrank below the current count end the period immediately
        boundary = (run_q == RUN) && (cnt_q >= active_div_q - 32'd1);
        pending_div_d = speed_reset                ? DEFAULT_DIV :
                        (speed_up && speed_down)   ? pending_div_q :
                        speed_up                   ? dec_div :
                        speed_down                 ? inc_div : pending_div_q;
        // the active divider only moves between periods or while paused
        active_div_d = (boundary || run_q == PAUSED) ? pending_div_q : active_div_q;
        cnt_d        = (run_q == PAUSED) ? cnt_q : boundary ? 32'd0 : cnt_q + 32'd1;
        run_d        = pause ? PAUSED : RUN;
        hs_d         = boundary ? REQ_PEND : (hs_q == REQ_PEND && sample_ack) ? REQ_IDLE : hs_q;
        overrun_d    = overrun_q || (boundary && hs_q == REQ_PEND && !sample_ack);
    end

    assign sample_req  = (hs_q == REQ_PEND);
    assign running     = (run_q == RUN);
    assign divider_out = active_div_q;
    assign overrun     = overrun_q;
endmodule
